mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

Parametrised March-test MBIST controller for the memory under test (`test_mem`), generalising the hand-written write-then-read stimulus into a self-checking engine. It sweeps every address with a selectable March algorithm (March C- or MATS+), drives the memory's `wen`/`ren`/`address`/`din` pins, and compares read data one cycle after each read. It reports pass/fail with first-failure diagnostics. It sits between the test top-level and a single-port memory instance of matching `addr`/`data` widths.

## Interface
- `ADDR`, 4, address width; depth N = 2^ADDR
- `DATA`, 8, data word width; background pattern is all-0 / all-1 of this width
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `algo`  in  1  0 = March C- (10N ops), 1 = MATS+ (5N ops); sampled with `start`
- `mem_wen`  out  1  memory write enable
- `mem_ren`  out  1  memory read enable
- `mem_addr`  out  ADDR  memory address
- `mem_din`  out  DATA  memory write data
- `mem_dout`  in  DATA  memory read data, valid the cycle after `mem_ren`
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until next accepted `start` or reset
- `pass`  out  1  valid when `done`; 1 = no mismatch
- `fail_addr`  out  ADDR  address of first mismatch
- `fail_exp`  out  DATA  expected word of first mismatch
- `fail_act`  out  DATA  captured `mem_dout` of first mismatch
- `fail_elem`  out  3  March element index (0-based) of first mismatch

## Operation
- States: IDLE -> RUN on `start`; RUN -> DRAIN after last op issued; DRAIN -> DONE after final compare; RUN/DRAIN -> DONE immediately on mismatch; DONE -> RUN on `start`.
- March C- elements: 0 up(w0); 1 up(r0,w1); 2 up(r1,w0); 3 down(r0,w1); 4 down(r1,w0); 5 up(r0). MATS+: 0 up(w0); 1 up(r0,w1); 2 down(r1,w0).
- "0"/"1" mean all-zeros / all-ones DATA-bit words. Up = address 0 to N-1, down = N-1 to 0, wrapping into the next element with no idle cycle.
- One op per cycle: a write drives `mem_wen`=1, `mem_ren`=0; a read drives `mem_ren`=1, `mem_wen`=0. `mem_din`=0 during reads.
- The expected word and element index for each read are pipelined one stage. Compare `mem_dout` against them in the following cycle.
- First mismatch: capture `fail_*` and abort, with no further ops issued. The op already on the bus in the compare cycle completes.
- `start` in RUN/DRAIN is ignored. `start` held high in DONE retriggers. An accepted `start` clears `done`, `pass` and `fail_*`.

## Timing
- Reset values: all outputs 0, state IDLE. Reset takes effect immediately, including mid-run. The memory is not restored.
- All outputs are registered. If `start` is sampled at edge k, `busy`=1 and op 0 are on the bus in the cycle after edge k.
- Fault-free run: `busy` high for ops+1 cycles (161 for March C-, 81 for MATS+ at ADDR=4). `done`/`pass` rise in the following cycle as `busy` falls.
- Mismatch detected at edge e: in the cycle after e, `busy`=0, `done`=1, `pass`=0 and the bus is idle.
- Address counter is ADDR bits wide. Element ends on terminal count (N-1 up, 0 down); no carry out is used.

## Structure
- `mbist_pkg`: state enum, algo codes, element descriptor (direction, op count, op0/op1 read-or-write and value), March C-/MATS+ element tables, `ELEM_W`=3.
- Sub-module `mbist_addr_gen`: loadable up/down ADDR-bit counter with terminal-count flag.
- The controller holds the FSM, op sequencing, the 1-stage compare pipeline and the failure capture registers.

## Test plan
- Reset held low, then released with `start`=0 -> all outputs 0, bus idle, state IDLE.
- `algo`=0, `start` pulse, fault-free `test_mem` #(4,8) -> `busy` for 161 cycles, then `done`=1, `pass`=1, and all 16 words read 8'h00.
- `algo`=1, `start` pulse, fault-free memory -> `busy` for 81 cycles, `pass`=1, memory all 8'h00.
- `mem_dout` bit 0 stuck at 1 when address 5 is read, `algo`=0 -> `pass`=0, `fail_addr`=5, `fail_exp`=8'h00, `fail_act`=8'h01, `fail_elem`=1.
- `rst_n` low in cycle 50 of a March C- run -> outputs 0 asynchronously. A subsequent `start` completes in 161 cycles with `pass`=1.
- `start` pulsed mid-run -> ignored, run length unchanged. `start` held high through DONE -> second run begins the cycle after `done`, with `done`/`pass` cleared.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and March element tables for the MBIST controller.
// An element descriptor is {down, two, op0_wr, op0_val, op1_wr, op1_val}.
package mbist_pkg;

    localparam int ELEM_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic ALGO_MARCH_C = 1'b0;
    localparam logic ALGO_MATS    = 1'b1;

    localparam logic [ELEM_W-1:0] MARCH_C_LAST = 3'd5;
    localparam logic [ELEM_W-1:0] MATS_LAST    = 3'd2;

    typedef struct packed {
        logic down;
        logic two;
        logic op0_wr;
        logic op0_val;
        logic op1_wr;
        logic op1_val;
    } elem_desc_t;

    // Row index is the algo code; bit groups are down_two_op0_op1, op = {wr,val}.
    localparam elem_desc_t ELEM_TBL [2][8] = '{
        '{elem_desc_t'(6'b0_0_10_00), elem_desc_t'(6'b0_1_00_11),
          elem_desc_t'(6'b0_1_01_10), elem_desc_t'(6'b1_1_00_11),
          elem_desc_t'(6'b1_1_01_10), elem_desc_t'(6'b0_0_00_00),
          elem_desc_t'(6'b0_0_00_00), elem_desc_t'(6'b0_0_00_00)},
        '{elem_desc_t'(6'b0_0_10_00), elem_desc_t'(6'b0_1_00_11),
          elem_desc_t'(6'b1_1_01_10), elem_desc_t'(6'b0_0_00_00),
          elem_desc_t'(6'b0_0_00_00), elem_desc_t'(6'b0_0_00_00),
          elem_desc_t'(6'b0_0_00_00), elem_desc_t'(6'b0_0_00_00)}
    };

    function automatic logic is_last_elem(input logic algo, input logic [ELEM_W-1:0] e);
        return e == ((algo == ALGO_MATS) ? MATS_LAST : MARCH_C_LAST);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; tc flags the last address of the current sweep.
module mbist_addr_gen #(
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            load_down,
    input  logic            step,
    output logic [ADDR-1:0] addr,
    output logic            tc
);

    logic down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            down <= load_down;
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR'(1) : addr + ADDR'(1);
        end
    end

    assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- / MATS+ MBIST engine: issues one memory op per cycle, checks each
// read one cycle later and stops on the first mismatch with diagnostics.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR = 4,
    parameter int DATA = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              algo,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR-1:0]   mem_addr,
    output logic [DATA-1:0]   mem_din,
    input  logic [DATA-1:0]   mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR-1:0]   fail_addr,
    output logic [DATA-1:0]   fail_exp,
    output logic [DATA-1:0]   fail_act,
    output logic [ELEM_W-1:0] fail_elem
);

    state_t            state;
    logic              algo_q;
    logic [ELEM_W-1:0] elem_q;
    logic              opsel_q;
    logic              rd_val;

    logic              chk_vld;
    logic [DATA-1:0]   chk_exp;
    logic [ADDR-1:0]   chk_addr;
    logic [ELEM_W-1:0] chk_elem;

    logic              tc, accept, mism, last_op, adv_elem, last_elem, fin;
    logic [ELEM_W-1:0] elem_n;
    logic              opsel_n, nxt_wr, nxt_val;
    logic              ag_load, ag_down, ag_step;

    // start is a level request with no ready: it is taken only while idle or
    // done, and busy high marks the window in which it is ignored.
    always_comb begin
        accept    = start && (state == S_IDLE || state == S_DONE);
        mism      = chk_vld && (mem_dout != chk_exp);
        last_op   = !ELEM_TBL[algo_q][elem_q].two || opsel_q;
        adv_elem  = last_op && tc;
        last_elem = is_last_elem(algo_q, elem_q);
        fin       = adv_elem && last_elem;
        elem_n    = adv_elem ? elem_q + ELEM_W'(1) : elem_q;
        opsel_n   = !last_op;
        nxt_wr    = opsel_n ? ELEM_TBL[algo_q][elem_n].op1_wr  : ELEM_TBL[algo_q][elem_n].op0_wr;
        nxt_val   = opsel_n ? ELEM_TBL[algo_q][elem_n].op1_val : ELEM_TBL[algo_q][elem_n].op0_val;
        ag_load   = accept || (state == S_RUN && !mism && adv_elem && !last_elem);
        ag_down   = !accept && ELEM_TBL[algo_q][elem_n].down;
        ag_step   = (state == S_RUN) && !mism && last_op && !tc;
    end

    mbist_addr_gen #(.ADDR(ADDR)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_down),
        .step      (ag_step),
        .addr      (mem_addr),
        .tc        (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            algo_q    <= 1'b0;
            elem_q    <= '0;
            opsel_q   <= 1'b0;
            rd_val    <= 1'b0;
            chk_vld   <= 1'b0;
            chk_exp   <= '0;
            chk_addr  <= '0;
            chk_elem  <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_RUN;
                        algo_q    <= algo;
                        elem_q    <= '0;
                        opsel_q   <= 1'b0;
                        rd_val    <= ELEM_TBL[algo][0].op0_val;
                        chk_vld   <= 1'b0;
                        mem_wen   <= ELEM_TBL[algo][0].op0_wr;
                        mem_ren   <= !ELEM_TBL[algo][0].op0_wr;
                        mem_din   <= ELEM_TBL[algo][0].op0_wr ? {DATA{ELEM_TBL[algo][0].op0_val}} : '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_act  <= '0;
                        fail_elem <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    // Compare stage: tag the op on the bus with what its read must return.
                    chk_vld  <= mem_ren && (state == S_RUN);
                    chk_exp  <= {DATA{rd_val}};
                    chk_addr <= mem_addr;
                    chk_elem <= elem_q;
                    if (mism) begin
                        state     <= S_DONE;
                        chk_vld   <= 1'b0;
                        mem_wen   <= 1'b0;
                        mem_ren   <= 1'b0;
                        mem_din   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= chk_addr;
                        fail_exp  <= chk_exp;
                        fail_act  <= mem_dout;
                        fail_elem <= chk_elem;
                    end else if (state == S_DRAIN) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (fin) begin
                        state   <= S_DRAIN;
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        mem_din <= '0;
                    end else begin
                        elem_q  <= elem_n;
                        opsel_q <= opsel_n;
                        rd_val  <= nxt_val;
                        mem_wen <= nxt_wr;
                        mem_ren <= !nxt_wr;
                        mem_din <= nxt_wr ? {DATA{nxt_val}} : '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural memory with a stuck-bit fault, a
// March reference model built from element strings, and a bus scoreboard.
module tb_mbist_march_ctrl;

    localparam int ADDR = 4;
    localparam int DATA = 8;
    localparam int NW   = 1 << ADDR;
    localparam int OPW  = 2 + ADDR + DATA;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            algo;
    logic            mem_wen;
    logic            mem_ren;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_din;
    logic [DATA-1:0] mem_dout;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ADDR-1:0] fail_addr;
    logic [DATA-1:0] fail_exp;
    logic [DATA-1:0] fail_act;
    logic [2:0]      fail_elem;

    mbist_march_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .algo      (algo),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .fail_elem (fail_elem)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory under test with optional stuck bit ----------------
    logic [DATA-1:0] mem_arr [NW];
    bit              f_en;
    int              f_addr;
    int              f_bit;
    bit              f_val;

    always @(posedge clk) begin
        logic [DATA-1:0] rd;
        if (mem_wen) mem_arr[mem_addr] <= mem_din;
        if (mem_ren) begin
            rd = mem_arr[mem_addr];
            if (f_en && int'(mem_addr) == f_addr) rd[f_bit] = f_val;
            mem_dout <= rd;
        end
    end

    // ---------------- scoreboard state ----------------
    int              n_vec;
    int              n_err;
    logic [OPW-1:0]  exp_q[$];
    bit              m_pass;
    int              m_faddr, m_fexp, m_fact, m_felem, m_busy;

    typedef struct {
        bit algo;
        bit f_en;
        int f_addr;
        int f_bit;
        bit f_val;
        bit e_pass;
        int e_addr;
        int e_exp;
        int e_act;
        int e_elem;
        int e_busy;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 64'({busy, done, pass, mem_wen, mem_ren, mem_addr, mem_din,
                         fail_addr, fail_exp, fail_act, fail_elem}), 64'(0));
    endtask

    // Expands the algorithm into its op list, plays it against an array with the
    // same fault, and queues every bus word expected while busy is high.
    task automatic build_model(input bit alg);
        string           el[$];
        string           s;
        logic [OPW-1:0]  ops[$];
        logic [DATA-1:0] rdexp[$];
        int              elem_of[$];
        logic [DATA-1:0] m [NW];
        logic [DATA-1:0] w;
        logic [DATA-1:0] act;
        logic [ADDR-1:0] aa;
        int              nops, a;
        bit              wr, v;
        if (alg) el = '{"uw0", "ur0w1", "dr1w0"};
        else     el = '{"uw0", "ur0w1", "ur1w0", "dr0w1", "dr1w0", "ur0"};
        for (int e = 0; e < el.size(); e++) begin
            s = el[e];
            nops = (s.len() - 1) / 2;
            for (int k = 0; k < NW; k++) begin
                a = (s.getc(0) == "d") ? NW - 1 - k : k;
                aa = ADDR'(a);
                for (int o = 0; o < nops; o++) begin
                    wr = (s.getc(1 + 2 * o) == "w");
                    v  = (s.getc(2 + 2 * o) == "1");
                    w  = v ? '1 : '0;
                    ops.push_back({wr, !wr, aa, wr ? w : {DATA{1'b0}}});
                    rdexp.push_back(w);
                    elem_of.push_back(e);
                end
            end
        end
        m_pass = 1'b1; m_faddr = 0; m_fexp = 0; m_fact = 0; m_felem = 0;
        m_busy = ops.size() + 1;
        for (int i = 0; i < ops.size(); i++) begin
            aa = ops[i][DATA +: ADDR];
            if (ops[i][OPW-1]) begin
                m[aa] = ops[i][DATA-1:0];
            end else begin
                act = m[aa];
                if (f_en && int'(aa) == f_addr) act[f_bit] = f_val;
                if (act !== rdexp[i]) begin
                    m_pass  = 1'b0;
                    m_faddr = int'(aa);
                    m_fexp  = int'(rdexp[i]);
                    m_fact  = int'(act);
                    m_felem = elem_of[i];
                    m_busy  = i + 2;
                    break;
                end
            end
        end
        exp_q.delete();
        for (int i = 0; i < m_busy; i++) exp_q.push_back(i < ops.size() ? ops[i] : {OPW{1'b0}});
    endtask

    // One complete run: pulse start, score every busy cycle, then the result.
    task automatic run_case(input vec_t v, input bit from_model, input int mid);
        int             cyc;
        logic [OPW-1:0] e, a;
        f_en = v.f_en; f_addr = v.f_addr; f_bit = v.f_bit; f_val = v.f_val;
        build_model(v.algo);
        if (from_model) begin
            v.e_pass = m_pass; v.e_addr = m_faddr; v.e_exp = m_fexp;
            v.e_act = m_fact; v.e_elem = m_felem; v.e_busy = m_busy;
        end
        @(negedge clk);
        algo  = v.algo;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            a = {mem_wen, mem_ren, mem_addr, mem_din};
            e = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (e[OPW-1 -: 2] == 2'b00) a[DATA +: ADDR] = '0;
            check("bus_op", 64'(a), 64'(e));
            start = (cyc == mid);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 64'(cyc), 64'(v.e_busy));
        check("done", 64'(done), 64'(1));
        check("pass", 64'(pass), 64'(v.e_pass));
        check("fail_addr", 64'(fail_addr), 64'(v.e_addr));
        check("fail_exp", 64'(fail_exp), 64'(v.e_exp));
        check("fail_act", 64'(fail_act), 64'(v.e_act));
        check("fail_elem", 64'(fail_elem), 64'(v.e_elem));
        check("bus_idle", 64'({mem_wen, mem_ren, mem_din}), 64'(0));
        check("ops_left", 64'(exp_q.size()), 64'(0));
        if (v.e_pass)
            for (int i = 0; i < NW; i++) check("mem_word", 64'(mem_arr[i]), 64'(0));
    endtask

    initial begin
        vec_t v;
        int   cyc;
        n_vec = 0;
        n_err = 0;
        f_en  = 1'b0; f_addr = 0; f_bit = 0; f_val = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        algo  = 1'b0;

        // fields: algo, f_en, f_addr, f_bit, f_val, pass, addr, exp, act, elem, busy
        tbl[0] = '{0, 0,  0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 161};
        tbl[1] = '{1, 0,  0, 0, 0, 1,  0, 8'h00, 8'h00, 0,  81};
        tbl[2] = '{0, 1,  5, 0, 1, 0,  5, 8'h00, 8'h01, 1,  28};
        tbl[3] = '{1, 1,  3, 7, 0, 0,  3, 8'hff, 8'h7f, 2,  74};
        tbl[4] = '{0, 1, 10, 3, 0, 0, 10, 8'hff, 8'hf7, 2,  70};
        tbl[5] = '{0, 1, 15, 7, 1, 0, 15, 8'h00, 8'h80, 1,  48};

        // reset state
        repeat (3) @(negedge clk);
        check_idle("reset_values");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("idle_after_reset");

        // directed table
        for (int i = 0; i < 6; i++) run_case(tbl[i], 1'b0, -1);

        // asynchronous reset in cycle 50 of a March C- run, then a clean rerun
        @(negedge clk);
        algo = 1'b0; f_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        check_idle("held_reset");
        rst_n = 1'b1;
        run_case(tbl[0], 1'b0, -1);

        // start pulsed mid-run is ignored
        run_case(tbl[0], 1'b0, 40);
        run_case(tbl[1], 1'b0, 20);

        // randomized runs against the reference model
        for (int i = 0; i < 8; i++) begin
            v.algo   = 1'($urandom_range(0, 1));
            v.f_en   = ($urandom_range(0, 3) != 0);
            v.f_addr = int'($urandom_range(0, NW - 1));
            v.f_bit  = int'($urandom_range(0, DATA - 1));
            v.f_val  = 1'($urandom_range(0, 1));
            run_case(v, 1'b1, -1);
        end

        // start held high through DONE retriggers immediately
        @(negedge clk);
        algo = 1'b0; f_en = 1'b0; start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_run1_len", 64'(cyc), 64'(161));
        check("hold_done", 64'({done, pass}), 64'(2'b11));
        @(negedge clk);
        check("retrig_busy", 64'(busy), 64'(1));
        check("retrig_cleared", 64'({done, pass}), 64'(0));
        check("retrig_op0", 64'({mem_wen, mem_ren, mem_addr, mem_din}), 64'({2'b10, 4'd0, 8'h00}));
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_run2_len", 64'(cyc), 64'(161));
        check("hold_run2_pass", 64'({done, pass}), 64'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
